// File: rtl/display_pkg.sv
// Shared constants, state encoding and BCD helper for bcd_hex_display.
// Segment patterns are active-low, bit0 = segment a through bit6 = segment g.
package display_pkg;

   localparam int VALUE_W     = 14;
   localparam int DIGITS      = 4;
   localparam int BCD_W       = 4 * DIGITS;
   localparam int CNT_W       = 4;
   localparam int MAX_DISPLAY = 9999;

   // Counter value present on the edge that performs the final shift.
   localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(VALUE_W - 1);

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_DASH  = 7'h3F;
   localparam logic [6:0] SEG_DIGIT [0:9] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
      7'h12, 7'h02, 7'h78, 7'h00, 7'h10
   };

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CONVERT = 2'd1,
      ST_UPDATE  = 2'd2
   } disp_state_t;

   // Double-dabble correction: any nibble >= 5 gets +3 before the shift.
   function automatic logic [BCD_W-1:0] bcd_adjust(input logic [BCD_W-1:0] bcd);
      logic [BCD_W-1:0] res;
      res = bcd;
      for (int i = 0; i < DIGITS; i++) begin
         if (bcd[4*i +: 4] >= 4'd5) begin
            res[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/seven_seg_decoder.sv
// Combinational BCD-to-seven-segment decoder with a blank override.
// Non-decimal nibbles also decode to blank.
module seven_seg_decoder
   import display_pkg::*;
(
   input  logic [3:0] i_bcd,
   input  logic       i_blank,
   output logic [6:0] o_seg
);

   always_comb begin
      o_seg = SEG_BLANK;
      if (!i_blank && (i_bcd <= 4'd9)) begin
         o_seg = SEG_DIGIT[i_bcd];
      end
   end

endmodule

// File: rtl/bcd_hex_display.sv
// Binary-to-BCD display stage: valid/ready input, sequential double-dabble, registered HEX0-HEX3.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zeros on HEX3..HEX1.
module bcd_hex_display
   import display_pkg::*;
(
   input  logic               CLOCK_50,
   input  logic               reset,
   input  logic [VALUE_W-1:0] value_in,
   input  logic               value_valid,
   output logic               value_ready,
   output logic               done,
   output logic               overflow,
   output logic [6:0]         HEX0,
   output logic [6:0]         HEX1,
   output logic [6:0]         HEX2,
   output logic [6:0]         HEX3
);

   disp_state_t        r_state;
   disp_state_t        w_state_next;
   logic [VALUE_W-1:0] r_bin;
   logic [VALUE_W-1:0] r_value;
   logic [BCD_W-1:0]   r_bcd;
   logic [BCD_W-1:0]   w_bcd_adj;
   logic [CNT_W-1:0]   r_cnt;
   logic [6:0]         r_hex [DIGITS];
   logic               r_done;
   logic               r_overflow;
   logic               w_accept;
   logic               w_overflow;
   logic [DIGITS-1:0]  w_blank;
   logic [6:0]         w_seg [DIGITS];

   assign value_ready = (r_state == ST_IDLE);
   assign w_accept    = value_valid && value_ready;
   assign w_bcd_adj   = bcd_adjust(r_bcd);
   assign w_overflow  = (r_value > VALUE_W'(MAX_DISPLAY));

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               w_state_next = ST_CONVERT;
            end
         end
         ST_CONVERT: begin
            if (r_cnt == LAST_SHIFT) begin
               w_state_next = ST_UPDATE;
            end
         end
         ST_UPDATE: begin
            w_state_next = ST_IDLE;
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   // Leading-zero suppression chains from the most significant digit down.
`ifdef LEADING_ZERO_BLANK_EN
   assign w_blank[DIGITS-1] = (r_bcd[4*(DIGITS-1) +: 4] == 4'd0);
   assign w_blank[0]        = 1'b0;
   generate
      for (genvar gi = 1; gi < DIGITS - 1; gi++) begin : g_lead_blank
         assign w_blank[gi] = w_blank[gi+1] && (r_bcd[4*gi +: 4] == 4'd0);
      end
   endgenerate
`else
   assign w_blank = '0;
`endif

   generate
      for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
         seven_seg_decoder u_dec (
            .i_bcd   (r_bcd[4*gi +: 4]),
            .i_blank (w_blank[gi]),
            .o_seg   (w_seg[gi])
         );
      end
   endgenerate

   // The unshifted copy in r_value decides overflow, since r_bin is consumed by the shifts.
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         r_bin      <= '0;
         r_value    <= '0;
         r_bcd      <= '0;
         r_cnt      <= '0;
         r_done     <= 1'b0;
         r_overflow <= 1'b0;
         for (int i = 0; i < DIGITS; i++) begin
            r_hex[i] <= SEG_BLANK;
         end
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_bin   <= value_in;
                  r_value <= value_in;
                  r_bcd   <= '0;
                  r_cnt   <= '0;
               end
            end
            ST_CONVERT: begin
               {r_bcd, r_bin} <= {w_bcd_adj, r_bin} << 1;
               r_cnt          <= r_cnt + 1'b1;
            end
            ST_UPDATE: begin
               r_done     <= 1'b1;
               r_overflow <= w_overflow;
               for (int i = 0; i < DIGITS; i++) begin
                  r_hex[i] <= w_overflow ? SEG_DASH : w_seg[i];
               end
            end
            default: begin
               r_done <= 1'b0;
            end
         endcase
      end
   end

   assign done     = r_done;
   assign overflow = r_overflow;
   assign HEX0     = r_hex[0];
   assign HEX1     = r_hex[1];
   assign HEX2     = r_hex[2];
   assign HEX3     = r_hex[3];

endmodule

// File: doc/bcd_hex_display.md
# bcd_hex_display

Downstream output stage of the board-level integration design. Accepts a 14-bit binary result through a valid/ready handshake and converts it to four BCD digits with a sequential shift-add-3 (double-dabble) engine. Drives the active-low seven-segment outputs HEX0–HEX3 from registers, so the displays never show partial conversions.

## Interface
- `CLOCK_50` in 1: system clock; all state changes on its rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `value_in` in 14: unsigned binary value to display.
- `value_valid` in 1: `value_in` is valid this cycle.
- `value_ready` out 1: block can accept a value. High only in IDLE; combinational from state.
- `done` out 1: one-cycle pulse when HEX outputs update.
- `overflow` out 1: registered; 1 when the last accepted value was greater than 9999.
- `HEX0` out 7: ones digit. Active-low; bit0=a … bit6=g.
- `HEX1` out 7: tens digit.
- `HEX2` out 7: hundreds digit.
- `HEX3` out 7: thousands digit.

## Operation
- **States.** IDLE, CONVERT, UPDATE.
- **IDLE.**
  - On `value_valid && value_ready`, latch `value_in` into a 14-bit shift register.
  - Clear the 16-bit BCD accumulator.
  - Clear the 4-bit iteration counter.
  - Go to CONVERT.
- **CONVERT.** Each cycle:
  - Every BCD nibble that is ≥5 gets +3.
  - Then shift {bcd, bin} left by 1.
  - The counter increments.
  - After 14 shifts (counter=13 at the edge), go to UPDATE.
- **UPDATE.**
  - If the latched value is greater than 9999: `overflow`=1, and every HEX shows a dash (7'b0111111).
  - Otherwise: `overflow`=0, and each nibble is decoded to its segment pattern.
  - `done`=1 for this cycle only.
  - Return to IDLE.
- **Segment patterns.**
  - Digits: 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10.
  - Blank = 7'h7F.
- **Handshake and input changes.**
  - `value_valid` is ignored outside IDLE; there is no queuing.
  - The upstream stage holds its value until it sees ready.
  - Changes to `value_in` during CONVERT have no effect.
- **Reset.** Reset mid-conversion aborts the conversion. HEX outputs go blank and the partial result is discarded.

## Timing
- **Reset values.**
  - State=IDLE, so `value_ready`=1.
  - `done`=0, `overflow`=0.
  - HEX0–HEX3 = 7'h7F.
  - Internal registers = 0.
- **Latency.** Handshake at edge N → HEX, `overflow` and `done` valid after edge N+15. Breakdown: 14 CONVERT cycles plus 1 UPDATE.
- **Throughput.** One value per 16 cycles.
- **Back-to-back.**
  - If `value_valid` is held high, the next accept happens at the edge after UPDATE (N+16).
  - `value_ready` is low from N+1 through N+15 inclusive.
- **Output stability.** HEX outputs change only at the UPDATE edge and hold otherwise.

## Configuration
- **`LEADING_ZERO_BLANK_EN` defined.**
  - Leading zero digits in HEX3, HEX2 and HEX1 show blank (7'h7F).
  - HEX0 always shows its digit, so value 0 shows a single "0".
  - Overflow dashes are unaffected.
- **Not defined.** All four digits are always shown, including leading zeros.

## Structure
- **Package `display_pkg`.**
  - Segment pattern constants: `SEG_DIGIT[0:9]`, `SEG_BLANK`, `SEG_DASH`.
  - `VALUE_W`=14, `DIGITS`=4, `MAX_DISPLAY`=9999.
  - State enum `disp_state_t`.
- **Sub-module `seven_seg_decoder`.**
  - Combinational: 4-bit BCD plus a blank input → 7-bit active-low segments.
  - Instantiated four times; outputs registered in the parent.

## Test plan
- **Reset.**
  - Stimulus: assert `reset` for 2 cycles.
  - Response: HEX0–3 = 7'h7F, `value_ready`=1, `done`=0, `overflow`=0.
- **Basic conversion.**
  - Stimulus: accept 1234.
  - Response: after 15 edges, HEX3=7'h79, HEX2=7'h24, HEX1=7'h30, HEX0=7'h19. `done` pulses once. `value_ready` is low during conversion.
- **Boundaries.**
  - Stimulus: accept 9999, then 10000, then 16383.
  - Response for 9999: all four HEX = 7'h10, `overflow`=0.
  - Response for 10000 and 16383: all HEX = 7'h3F, `overflow`=1.
- **Back-to-back.**
  - Stimulus: `value_valid` held high while `value_in` changes 0→7 during CONVERT.
  - Response: the first result shows 0000 (without the macro). The second accept happens exactly 16 cycles after the first.
- **Reset mid-conversion.**
  - Stimulus: accept 4321, then assert `reset` at cycle 7.
  - Response: HEX = blank, no `done` pulse. A later 5 converts correctly.
- **Macro.**
  - Stimulus: accept 42.
  - Response without `LEADING_ZERO_BLANK_EN`: HEX3=HEX2=7'h40.
  - Response with it: HEX3=HEX2=7'h7F.
  - In both cases HEX1=7'h19, HEX0=7'h24.
  - With the macro, value 0 → HEX0=7'h40 and the others blank.
